// File: rtl/prio_arbiter_pkg.sv
// Shared types and constants for the prio_arbiter block.
// Covers the FSM state encoding and the selection-mode constants.
package prio_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

endpackage

// File: rtl/prio_arbiter_if.sv
// Requester-side bus of the arbiter: request lines, release strobe, and the held grant.
interface prio_arbiter_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    // Protocol: requesters raise req[i] and keep it up until granted. The grant
    // (gnt_vld/gnt_idx/gnt_oh) is held until the owner pulses done for one cycle
    // or the hold timeout forces a release (tmo pulses the cycle after). done is
    // ignored while gnt_vld=0.
    logic [N-1:0] req;
    logic         done;
    logic         gnt_vld;
    logic [W-1:0] gnt_idx;
    logic [N-1:0] gnt_oh;
    logic         tmo;

    modport master (output req, done, input gnt_vld, gnt_idx, gnt_oh, tmo);
    modport slave  (input req, done, output gnt_vld, gnt_idx, gnt_oh, tmo);

endinterface

// File: rtl/prio_arbiter_pick.sv
// Combinational picker: the highest set bit of vec when vec is rotated so
// that bit 'start' sits at the top; idx is returned in un-rotated numbering.
module prio_pick #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [N-1:0] rot;
    int           pos;

    always_comb begin
        rot = '0;
        for (int j = 0; j < N; j++) begin
            rot[j] = vec[(int'(start) + 1 + j) % N];
        end

        found = |rot;
        pos   = 0;
        for (int j = 0; j < N; j++) begin
            if (rot[j]) pos = j;
        end

        idx = W'((int'(start) + 1 + pos) % N);
    end

endmodule

// File: rtl/prio_arbiter.sv
// Registered N-way arbiter with held grants: fixed highest-index or round-robin
// selection, released by done or an optional hold timeout.
module prio_arbiter
    import prio_arbiter_pkg::*;
#(
    parameter int N   = 8,
    parameter int RR  = 0,
    parameter int TMO = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    prio_arbiter_if.slave   bus,
    output state_t          dbg_state
);

    localparam int W  = $clog2(N);
    localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  last_q;
    logic          vld_q;
    logic [W-1:0]  idx_q;
    logic [N-1:0]  oh_q;
    logic          tmo_q;

    logic [W-1:0]  start;
    logic          found;
    logic [W-1:0]  sel;
    logic          tmo_hit;
    logic          rel;

    // Round-robin searches from last-1 downwards, so last itself is tried last.
    always_comb begin
        if (RR == MODE_RR) begin
            start = (last_q == '0) ? W'(N - 1) : last_q - W'(1);
        end else begin
            start = W'(N - 1);
        end
    end

    prio_pick #(.N(N), .W(W)) u_pick (
        .vec   (bus.req),
        .start (start),
        .found (found),
        .idx   (sel)
    );

    assign tmo_hit = (TMO != 0) && (cnt_q == CW'(TMO - 1));
    assign rel     = bus.done || tmo_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
            vld_q   <= 1'b0;
            idx_q   <= '0;
            oh_q    <= '0;
            tmo_q   <= 1'b0;
        end else begin
            tmo_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        state_q <= GRANT;
                        cnt_q   <= '0;
                        last_q  <= sel;
                        vld_q   <= 1'b1;
                        idx_q   <= sel;
                        oh_q    <= N'(1) << sel;
                    end
                end
                GRANT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (rel) begin
                        // done has priority: a coinciding timeout is not flagged.
                        tmo_q <= tmo_hit && !bus.done;
                        if (found) begin
                            cnt_q  <= '0;
                            last_q <= sel;
                            idx_q  <= sel;
                            oh_q   <= N'(1) << sel;
                        end else begin
                            state_q <= IDLE;
                            vld_q   <= 1'b0;
                            idx_q   <= '0;
                            oh_q    <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt_vld = vld_q;
    assign bus.gnt_idx = idx_q;
    assign bus.gnt_oh  = oh_q;
    assign bus.tmo     = tmo_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// Bench for prio_arbiter: four configurations driven side by side and checked
// every cycle against a behavioural model, plus directed checks of known sequences.
module tb_prio_arbiter;
    import prio_arbiter_pkg::*;

    localparam int NCFG = 4;
    localparam int N_CFG   [NCFG] = '{8, 8, 8, 5};
    localparam int RR_CFG  [NCFG] = '{0, 1, 0, 1};
    localparam int TMO_CFG [NCFG] = '{0, 0, 4, 0};

    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] req_v  [NCFG];
    logic       done_v [NCFG];

    logic       o_vld [NCFG];
    logic [7:0] o_idx [NCFG];
    logic [7:0] o_oh  [NCFG];
    logic       o_tmo [NCFG];
    state_t     o_st  [NCFG];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    prio_arbiter_if #(.N(8)) if_fix ();
    prio_arbiter_if #(.N(8)) if_rr  ();
    prio_arbiter_if #(.N(8)) if_tmo ();
    prio_arbiter_if #(.N(5)) if_n5  ();

    assign if_fix.req  = req_v[0];
    assign if_fix.done = done_v[0];
    assign if_rr.req   = req_v[1];
    assign if_rr.done  = done_v[1];
    assign if_tmo.req  = req_v[2];
    assign if_tmo.done = done_v[2];
    assign if_n5.req   = req_v[3][4:0];
    assign if_n5.done  = done_v[3];

    prio_arbiter #(.N(8), .RR(0), .TMO(0)) dut_fix (.clk(clk), .rst_n(rst_n), .bus(if_fix), .dbg_state(o_st[0]));
    prio_arbiter #(.N(8), .RR(1), .TMO(0)) dut_rr  (.clk(clk), .rst_n(rst_n), .bus(if_rr),  .dbg_state(o_st[1]));
    prio_arbiter #(.N(8), .RR(0), .TMO(4)) dut_tmo (.clk(clk), .rst_n(rst_n), .bus(if_tmo), .dbg_state(o_st[2]));
    prio_arbiter #(.N(5), .RR(1), .TMO(0)) dut_n5  (.clk(clk), .rst_n(rst_n), .bus(if_n5),  .dbg_state(o_st[3]));

    assign o_vld[0] = if_fix.gnt_vld;
    assign o_idx[0] = {5'b0, if_fix.gnt_idx};
    assign o_oh[0]  = if_fix.gnt_oh;
    assign o_tmo[0] = if_fix.tmo;
    assign o_vld[1] = if_rr.gnt_vld;
    assign o_idx[1] = {5'b0, if_rr.gnt_idx};
    assign o_oh[1]  = if_rr.gnt_oh;
    assign o_tmo[1] = if_rr.tmo;
    assign o_vld[2] = if_tmo.gnt_vld;
    assign o_idx[2] = {5'b0, if_tmo.gnt_idx};
    assign o_oh[2]  = if_tmo.gnt_oh;
    assign o_tmo[2] = if_tmo.tmo;
    assign o_vld[3] = if_n5.gnt_vld;
    assign o_idx[3] = {5'b0, if_n5.gnt_idx};
    assign o_oh[3]  = {3'b0, if_n5.gnt_oh};
    assign o_tmo[3] = if_n5.tmo;

    // ---------------- behavioural reference model ----------------
    int m_vld  [NCFG];
    int m_idx  [NCFG];
    int m_held [NCFG];
    int m_last [NCFG];
    int m_tmo  [NCFG];

    // Winner among the first n request bits, or -1 when none is set.
    function automatic int model_pick(logic [7:0] r, int n, int rr, int last);
        if (rr == 0) begin
            for (int i = n - 1; i >= 0; i--) if (r[i]) return i;
            return -1;
        end
        for (int k = 1; k <= n; k++) begin
            if (r[(last - k + n) % n]) return (last - k + n) % n;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < NCFG; d++) begin
            int p;
            int timed_out;
            if (!rst_n) begin
                m_vld[d] <= 0; m_idx[d] <= 0; m_held[d] <= 0; m_last[d] <= 0; m_tmo[d] <= 0;
            end else if (m_vld[d] == 0) begin
                m_tmo[d] <= 0;
                p = model_pick(req_v[d], N_CFG[d], RR_CFG[d], m_last[d]);
                if (p >= 0) begin
                    m_vld[d] <= 1; m_idx[d] <= p; m_held[d] <= 1; m_last[d] <= p;
                end
            end else begin
                timed_out = (TMO_CFG[d] != 0 && m_held[d] == TMO_CFG[d]) ? 1 : 0;
                if (done_v[d] || timed_out != 0) begin
                    m_tmo[d] <= (timed_out != 0 && !done_v[d]) ? 1 : 0;
                    p = model_pick(req_v[d], N_CFG[d], RR_CFG[d], m_last[d]);
                    if (p >= 0) begin
                        m_idx[d] <= p; m_held[d] <= 1; m_last[d] <= p;
                    end else begin
                        m_vld[d] <= 0; m_idx[d] <= 0; m_held[d] <= 0;
                    end
                end else begin
                    m_tmo[d]  <= 0;
                    m_held[d] <= m_held[d] + 1;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < NCFG; d++) begin
            logic [7:0] exp_oh;
            exp_oh = (m_vld[d] != 0) ? (8'd1 << m_idx[d]) : 8'd0;
            chk($sformatf("d%0d_vld", d), 32'(o_vld[d]), 32'(m_vld[d]));
            chk($sformatf("d%0d_oh", d), 32'(o_oh[d]), 32'(exp_oh));
            chk($sformatf("d%0d_tmo", d), 32'(o_tmo[d]), 32'(m_tmo[d]));
            chk($sformatf("d%0d_state", d), 32'(o_st[d] == GRANT), 32'(m_vld[d] != 0));
            if (m_vld[d] != 0) begin
                chk($sformatf("d%0d_idx", d), 32'(o_idx[d]), 32'(m_idx[d]));
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < NCFG; d++) begin
            req_v[d]  = 8'h00;
            done_v[d] = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int exp_rr [5];
        int exp_n5 [4];
        exp_rr = '{5, 2, 1, 5, 2};
        exp_n5 = '{4, 0, 4, 0};

        rst_n = 1'b0;
        clear_inputs();
        step();
        step();
        for (int d = 0; d < NCFG; d++) begin
            chk("reset_vld", 32'(o_vld[d]), 32'd0);
            chk("reset_idx", 32'(o_idx[d]), 32'd0);
            chk("reset_oh", 32'(o_oh[d]), 32'd0);
            chk("reset_tmo", 32'(o_tmo[d]), 32'd0);
        end
        rst_n = 1'b1;
        step();

        // Fixed priority: first grant and hold while req wanders.
        req_v[0] = 8'b0010_0110;
        step();
        chk("fix_first_vld", 32'(o_vld[0]), 32'd1);
        chk("fix_first_idx", 32'(o_idx[0]), 32'd5);
        chk("fix_first_oh", 32'(o_oh[0]), 32'h20);
        for (int k = 0; k < 6; k++) begin
            req_v[0] = 8'($urandom_range(0, 255));
            step();
            chk("fix_hold_idx", 32'(o_idx[0]), 32'd5);
            chk("fix_hold_vld", 32'(o_vld[0]), 32'd1);
        end
        req_v[0]  = 8'h00;
        done_v[0] = 1'b1;
        step();
        chk("fix_release_vld", 32'(o_vld[0]), 32'd0);
        done_v[0] = 1'b0;
        step();

        // Back-to-back grants with done held: round-robin vs fixed.
        req_v[0] = 8'b0010_0110; req_v[1] = 8'b0010_0110;
        done_v[0] = 1'b1;        done_v[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_seq_vld", 32'(o_vld[1]), 32'd1);
            chk("rr_seq_idx", 32'(o_idx[1]), 32'(exp_rr[k]));
            if (k < 3) chk("fix_seq_idx", 32'(o_idx[0]), 32'd5);
        end
        req_v[0] = 8'h00; req_v[1] = 8'h00;
        step();

        // Empty requests with done pulsing: nothing happens.
        for (int k = 0; k < 4; k++) begin
            done_v[0] = k[0]; done_v[1] = ~k[0];
            step();
            chk("empty_vld", 32'(o_vld[1]), 32'd0);
            chk("empty_oh", 32'(o_oh[0]), 32'd0);
            chk("empty_tmo", 32'(o_tmo[1]), 32'd0);
        end
        clear_inputs();
        step();

        // Timeout after exactly four held cycles, then re-grant.
        req_v[2] = 8'b0000_1000;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("tmo_hold_idx", 32'(o_idx[2]), 32'd3);
            chk("tmo_hold_flag", 32'(o_tmo[2]), 32'd0);
        end
        step();
        chk("tmo_pulse", 32'(o_tmo[2]), 32'd1);
        chk("tmo_regrant_idx", 32'(o_idx[2]), 32'd3);
        chk("tmo_regrant_vld", 32'(o_vld[2]), 32'd1);
        step();
        chk("tmo_single_pulse", 32'(o_tmo[2]), 32'd0);
        step();
        step();
        done_v[2] = 1'b1;
        step();
        chk("tmo_done_wins", 32'(o_tmo[2]), 32'd0);
        chk("tmo_done_regrant", 32'(o_vld[2]), 32'd1);
        req_v[2] = 8'h00;
        step();
        clear_inputs();
        step();

        // Reset in the middle of a round-robin grant.
        req_v[1] = 8'b0100_0000;
        step();
        chk("rst_pre_idx", 32'(o_idx[1]), 32'd6);
        req_v[1] = 8'hFF;
        rst_n    = 1'b0;
        step();
        chk("rst_mid_vld", 32'(o_vld[1]), 32'd0);
        chk("rst_mid_idx", 32'(o_idx[1]), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_after_idx", 32'(o_idx[1]), 32'd7);
        chk("rst_after_vld", 32'(o_vld[1]), 32'd1);
        req_v[1]  = 8'h00;
        done_v[1] = 1'b1;
        step();
        clear_inputs();

        // Non-power-of-two width, round-robin alternation.
        req_v[3]  = 8'b0001_0001;
        done_v[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("n5_seq_idx", 32'(o_idx[3]), 32'(exp_n5[k]));
        end
        req_v[3] = 8'h00;
        step();
        clear_inputs();
        step();

        // Random traffic, occasional reset, checked against the model.
        for (int k = 0; k < 600; k++) begin
            for (int d = 0; d < NCFG; d++) begin
                req_v[d]  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom & $urandom);
                if (d == 3) req_v[d] = req_v[d] & 8'h1F;
                done_v[d] = ($urandom_range(0, 2) == 0);
            end
            rst_n = ($urandom_range(0, 99) != 0);
            step();
            if (o_vld[3]) chk("n5_idx_range", 32'(o_idx[3] < 8'd5), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prio_arbiter.md
Name: prio_arbiter

Overview:
- Registered, parametrised successor to the team's 8-to-3 priority encoder: N request lines in, a held grant out.
- The grant is given as an index and as a one-hot vector, with a valid flag.
- Two selection modes: fixed priority (highest index wins, same convention as the encoder) and round-robin.
- Grants are held until the owner signals done or an optional hold timeout expires. Sits between N requesters and one shared resource.

Parameters:
- N, 8, number of request lines (2..32).
- RR, 0, mode: 0 = fixed highest-index priority; 1 = round-robin.
- TMO, 0, maximum cycles a grant may be held; 0 disables the timeout.
- W, $clog2(N), width of the grant index (derived; do not override).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  N  request vector, one bit per requester.
- done  in  1  current grant owner releases the resource; ignored when gnt_vld=0.
- gnt_vld  out  1  a grant is active.
- gnt_idx  out  W  index of the granted requester.
- gnt_oh  out  N  one-hot grant; all zeros when gnt_vld=0.
- tmo  out  1  one-cycle pulse on a forced release by timeout.

Behaviour:
- Reset: synchronous, active-low. While rst_n=0 at a rising edge: gnt_vld=0, gnt_idx=0, gnt_oh=0, tmo=0, state=IDLE, hold counter=0, RR pointer last=0. Applies mid-grant: the grant is dropped at that edge.
- All outputs are registered. No combinational path from req or done to any output.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0, select a requester; on the next edge go to GRANT with gnt_vld=1, gnt_idx=sel, gnt_oh=1<<sel. Latency is 1 cycle from req to grant.
  - If req==0, stay in IDLE.
- GRANT:
  - The grant is held regardless of req. The owner dropping its req does not release it.
  - The hold counter increments every cycle in GRANT.
  - Release occurs when done=1, or when TMO!=0 and the counter equals TMO-1 in that cycle.
  - On release, re-arbitrate in the same cycle using the current req: back-to-back grant if req!=0, otherwise go to IDLE with gnt_vld=0.
  - The counter clears on every new grant.
  - tmo=1 for exactly the cycle after a timeout release. If done and the timeout coincide, done wins and tmo stays 0.
- Fixed selection (RR=0): highest set bit of req.
- Round-robin selection (RR=1):
  - Search order is (last-1) mod N, (last-2) mod N, ..., last, wrapping. The first set bit wins.
  - last updates to the index of each new grant.
  - With last=0 after reset, the order starts at N-1, so the first grant matches fixed mode.
- done while in IDLE: no effect.
- The grant index is always < N. Non-power-of-two N is supported; unused index codes never appear.

Decomposition:
- Package prio_arbiter_pkg: state enum (IDLE, GRANT), mode constants MODE_FIXED=0 and MODE_RR=1.
- Sub-module prio_pick (combinational, parameter N): inputs vec[N] and start index; outputs found and idx. Rotates vec so that start becomes the top bit, picks the highest set bit, then un-rotates the index. Fixed mode instantiates it with start=N-1.
- The top level holds the FSM, hold counter, last pointer and output registers.

Test Plan:
- Fixed, N=8: req=8'b0010_0110 in IDLE -> next cycle gnt_vld=1, gnt_idx=5, gnt_oh=8'b0010_0000. Grant held while req toggles, until done.
- RR, N=8: req held at 8'b0010_0110, done pulsed on every grant cycle -> grant sequence 5,2,1,5,2. Fixed mode with the same stimulus -> 5,5,5. No IDLE cycle between grants.
- Empty/idle: req=0, done pulsed -> gnt_vld stays 0, gnt_oh=0, tmo=0 throughout.
- Timeout, TMO=4: req=8'b0000_1000, done never asserted -> gnt_vld=1 with idx 3 for exactly 4 cycles, then tmo pulses once and idx 3 is granted again. With done and the timeout in the same cycle -> tmo=0.
- Reset mid-grant: RR, grant idx 6 active, rst_n=0 for one edge with req=8'hFF -> at that edge gnt_vld=0, gnt_idx=0. After rst_n=1 the next grant is idx 7.
- Non-power-of-two, N=5: req=5'b10001 in RR with repeated done -> grants alternate 4,0,4,0. gnt_idx never exceeds 4.
